// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: write ports, read ports, reservation port and scoreboard view.
// Writes and reservations are single-cycle strobes sampled on the rising clock edge; there is no backpressure.
interface reg_file_mp_if #(
    parameter int W  = 8,
    parameter int D  = 4,
    parameter int NR = 2,
    parameter int NW = 2
);
    logic [NW-1:0]     we;
    logic [NW*D-1:0]   waddr;
    logic [NW*W-1:0]   wdata;
    logic [NR*D-1:0]   raddr;
    logic [NR*W-1:0]   rdata;
    logic [NR-1:0]     rbusy;
    logic              resv_en;
    logic [D-1:0]      resv_addr;
    logic [(2**D)-1:0] busy_vec;

    modport master (
        output we, waddr, wdata, raddr, resv_en, resv_addr,
        input  rdata, rbusy, busy_vec
    );

    modport slave (
        input  we, waddr, wdata, raddr, resv_en, resv_addr,
        output rdata, rbusy, busy_vec
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file with per-register busy scoreboard; register 0 is hardwired to zero.
// Optional same-cycle write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_mp #(
    parameter int W  = 8,
    parameter int D  = 4,
    parameter int NR = 2,
    parameter int NW = 2
) (
    input logic         clk,
    input logic         rst_n,
    reg_file_mp_if.slave bus
);
    localparam int DEPTH = 2 ** D;

    logic [W-1:0]     regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic [NR*W-1:0]  rdata_c;
    logic [NR-1:0]    rbusy_c;

    // Ascending port order makes the highest-index port the last assignment, so it wins conflicts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            for (int k = 0; k < NW; k++) begin
                if (bus.we[k] && (bus.waddr[k*D +: D] != '0)) begin
                    regs[bus.waddr[k*D +: D]] <= bus.wdata[k*W +: W];
                end
            end
            busy <= busy_nxt;
        end
    end

    // A reservation overrides a release of the same register: the new producer owns it.
    always_comb begin
        busy_nxt = busy;
        for (int k = 0; k < NW; k++) begin
            if (bus.we[k]) begin
                busy_nxt[bus.waddr[k*D +: D]] = 1'b0;
            end
        end
        if (bus.resv_en) begin
            busy_nxt[bus.resv_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        rdata_c = '0;
        rbusy_c = '0;
        for (int j = 0; j < NR; j++) begin
            rdata_c[j*W +: W] = regs[bus.raddr[j*D +: D]];
            rbusy_c[j]        = busy[bus.raddr[j*D +: D]];
`ifdef REG_FILE_BYPASS_EN
            for (int k = 0; k < NW; k++) begin
                if (bus.we[k] && (bus.waddr[k*D +: D] == bus.raddr[j*D +: D])
                    && (bus.waddr[k*D +: D] != '0)) begin
                    rdata_c[j*W +: W] = bus.wdata[k*W +: W];
                    rbusy_c[j]        = bus.resv_en && (bus.resv_addr == bus.raddr[j*D +: D]);
                end
            end
`endif
            if (bus.raddr[j*D +: D] == '0) begin
                rdata_c[j*W +: W] = '0;
                rbusy_c[j]        = 1'b0;
            end
        end
    end

    assign bus.rdata    = rdata_c;
    assign bus.rbusy    = rbusy_c;
    assign bus.busy_vec = busy;
endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: default build instance plus a W=16/D=5/NR=3/NW=1 sweep instance.
module tb_reg_file_mp;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    reg_file_mp_if #(.W(8), .D(4), .NR(2), .NW(2)) a ();
    reg_file_mp_if #(.W(16), .D(5), .NR(3), .NW(1)) b ();

    reg_file_mp #(.W(8), .D(4), .NR(2), .NW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a.slave)
    );

    reg_file_mp #(.W(16), .D(5), .NR(3), .NW(1)) dut_sweep (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]  m_regs [16];
    logic [15:0] m_busy;
    logic        we_d [2];
    int          wa_d [2];
    logic [7:0]  wd_d [2];
    int          ra_d [2];
    logic        rv_en_d;
    int          rv_addr_d;
    logic [7:0]  exp_q [$];

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_busy = 16'h0000;
    endtask

    task automatic model_commit();
        for (int k = 0; k < 2; k++)
            if (we_d[k] && wa_d[k] != 0) m_regs[wa_d[k]] = wd_d[k];
        for (int k = 0; k < 2; k++)
            if (we_d[k]) m_busy[wa_d[k]] = 1'b0;
        if (rv_en_d && rv_addr_d != 0) m_busy[rv_addr_d] = 1'b1;
        m_busy[0] = 1'b0;
    endtask

    function automatic logic [7:0] exp_rdata(input int ra);
        logic [7:0] v;
        v = (ra == 0) ? 8'h00 : m_regs[ra];
`ifdef REG_FILE_BYPASS_EN
        for (int k = 0; k < 2; k++)
            if (we_d[k] && wa_d[k] == ra && ra != 0) v = wd_d[k];
`endif
        return v;
    endfunction

    function automatic logic exp_rbusy(input int ra);
        logic v;
        v = (ra == 0) ? 1'b0 : m_busy[ra];
`ifdef REG_FILE_BYPASS_EN
        for (int k = 0; k < 2; k++)
            if (we_d[k] && wa_d[k] == ra && ra != 0) v = rv_en_d && (rv_addr_d == ra);
`endif
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic we0, input int wa0, input logic [7:0] wd0,
                         input logic we1, input int wa1, input logic [7:0] wd1,
                         input int ra0, input int ra1, input logic rv, input int rva);
        we_d[0] = we0; wa_d[0] = wa0; wd_d[0] = wd0;
        we_d[1] = we1; wa_d[1] = wa1; wd_d[1] = wd1;
        ra_d[0] = ra0; ra_d[1] = ra1;
        rv_en_d = rv; rv_addr_d = rva;
        a.we        = {we1, we0};
        a.waddr     = {wa1[3:0], wa0[3:0]};
        a.wdata     = {wd1, wd0};
        a.raddr     = {ra1[3:0], ra0[3:0]};
        a.resv_en   = rv;
        a.resv_addr = rva[3:0];
        #1;
    endtask

    task automatic drive_idle(input int ra0, input int ra1);
        drive(1'b0, 0, 8'h00, 1'b0, 0, 8'h00, ra0, ra1, 1'b0, 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++;
        if (a.rdata !== 16'h0000 || a.busy_vec !== 16'h0000 || a.rbusy !== 2'b00) begin
            failures++;
            $display("FAIL reset_initial rdata=%h busy_vec=%h rbusy=%b expected 0000/0000/00",
                     a.rdata, a.busy_vec, a.rbusy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 3, 8'hAA, 1'b0, 0, 8'h00, 3, 4, 1'b1, 4);
        cycle();
        drive_idle(3, 4);
        checks++;
        if (a.rdata[7:0] !== 8'hAA || a.busy_vec[4] !== 1'b1) begin
            failures++;
            $display("FAIL reset_prewrite rdata0=%h busy4=%b expected aa/1", a.rdata[7:0], a.busy_vec[4]);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (a.rdata !== 16'h0000 || a.busy_vec !== 16'h0000 || a.rbusy !== 2'b00) begin
            failures++;
            $display("FAIL reset_async rdata=%h busy_vec=%h rbusy=%b expected 0000/0000/00",
                     a.rdata, a.busy_vec, a.rbusy);
        end
        // Write and reservation presented while reset is held must be discarded.
        drive(1'b1, 6, 8'h77, 1'b0, 0, 8'h00, 6, 6, 1'b1, 6);
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        drive_idle(6, 6);
        @(negedge clk);
        checks++;
        if (a.rdata !== 16'h0000 || a.busy_vec !== 16'h0000) begin
            failures++;
            $display("FAIL reset_discard rdata=%h busy_vec=%h expected 0000/0000", a.rdata, a.busy_vec);
        end
    endtask

    task automatic test_zero_reg();
        drive(1'b1, 0, 8'h55, 1'b0, 0, 8'h00, 0, 0, 1'b1, 0);
        cycle();
        drive_idle(0, 0);
        checks++;
        if (a.rdata !== 16'h0000 || a.busy_vec[0] !== 1'b0 || a.rbusy !== 2'b00) begin
            failures++;
            $display("FAIL zero_reg rdata=%h busy0=%b rbusy=%b expected 0000/0/00",
                     a.rdata, a.busy_vec[0], a.rbusy);
        end
    endtask

    task automatic test_conflict();
        drive(1'b1, 5, 8'h11, 1'b1, 5, 8'h22, 1, 1, 1'b0, 0);
        cycle();
        drive_idle(5, 5);
        checks++;
        if (a.rdata !== 16'h2222) begin
            failures++;
            $display("FAIL port_conflict rdata=%h expected 2222", a.rdata);
        end
    endtask

    task automatic test_scoreboard();
        drive(1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 7, 7, 1'b1, 7);
        cycle();
        drive_idle(7, 7);
        checks++;
        if (a.busy_vec[7] !== 1'b1 || a.rbusy !== 2'b11) begin
            failures++;
            $display("FAIL sb_reserve busy7=%b rbusy=%b expected 1/11", a.busy_vec[7], a.rbusy);
        end
        drive(1'b0, 0, 8'h00, 1'b1, 7, 8'h3C, 7, 7, 1'b0, 0);
        checks++;
        if (a.rbusy !== {exp_rbusy(7), exp_rbusy(7)}) begin
            failures++;
            $display("FAIL sb_write_cycle_rbusy rbusy=%b expected %b%b", a.rbusy, exp_rbusy(7), exp_rbusy(7));
        end
        cycle();
        drive_idle(7, 7);
        checks++;
        if (a.busy_vec[7] !== 1'b0 || a.rdata !== 16'h3C3C) begin
            failures++;
            $display("FAIL sb_release busy7=%b rdata=%h expected 0/3c3c", a.busy_vec[7], a.rdata);
        end
        drive(1'b1, 7, 8'h44, 1'b0, 0, 8'h00, 7, 7, 1'b1, 7);
        cycle();
        drive_idle(7, 7);
        checks++;
        if (a.busy_vec[7] !== 1'b1 || a.rdata !== 16'h4444) begin
            failures++;
            $display("FAIL sb_resv_and_write busy7=%b rdata=%h expected 1/4444", a.busy_vec[7], a.rdata);
        end
    endtask

    task automatic test_bypass();
        logic [7:0] old_v;
        old_v = m_regs[2];
        drive(1'b1, 2, 8'h9F, 1'b0, 0, 8'h00, 2, 2, 1'b0, 0);
        checks++;
`ifdef REG_FILE_BYPASS_EN
        if (a.rdata !== 16'h9F9F) begin
            failures++;
            $display("FAIL bypass_same_cycle rdata=%h expected 9f9f", a.rdata);
        end
`else
        if (a.rdata !== {old_v, old_v}) begin
            failures++;
            $display("FAIL bypass_same_cycle rdata=%h expected %h%h", a.rdata, old_v, old_v);
        end
`endif
        cycle();
        drive_idle(2, 2);
        checks++;
        if (a.rdata !== 16'h9F9F) begin
            failures++;
            $display("FAIL bypass_next_cycle rdata=%h expected 9f9f", a.rdata);
        end
    endtask

    task automatic test_random();
        logic [7:0] got;
        logic [7:0] exp;
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom_range(0, 1)), $urandom_range(0, 15), 8'($urandom),
                  1'($urandom_range(0, 1)), $urandom_range(0, 15), 8'($urandom),
                  $urandom_range(0, 15), $urandom_range(0, 15),
                  1'($urandom_range(0, 2) == 0), $urandom_range(0, 15));
            exp_q.push_back(exp_rdata(ra_d[0]));
            exp_q.push_back(exp_rdata(ra_d[1]));
            for (int j = 0; j < 2; j++) begin
                got = a.rdata[j*8 +: 8];
                exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL rand_rdata iter=%0d port=%0d addr=%0d got=%h expected %h",
                             n, j, ra_d[j], got, exp);
                end
                checks++;
                if (a.rbusy[j] !== exp_rbusy(ra_d[j])) begin
                    failures++;
                    $display("FAIL rand_rbusy iter=%0d port=%0d got=%b expected %b",
                             n, j, a.rbusy[j], exp_rbusy(ra_d[j]));
                end
            end
            checks++;
            if (a.busy_vec !== m_busy) begin
                failures++;
                $display("FAIL rand_busy_vec iter=%0d got=%h expected %h", n, a.busy_vec, m_busy);
            end
            cycle();
        end
    endtask

    task automatic test_sweep();
        logic [15:0] exp;
        int          ra;
        for (int i = 0; i < 32; i++) begin
            b.we    = 1'b1;
            b.waddr = 5'(i);
            b.wdata = 16'(i * 3) ^ ((i == 0) ? 16'h5A5A : 16'h0000);
            @(posedge clk);
            @(negedge clk);
        end
        b.we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 3; j++) begin
                ra = (i + j * 11) % 32;
                b.raddr[j*5 +: 5] = 5'(ra);
            end
            #1;
            for (int j = 0; j < 3; j++) begin
                ra  = (i + j * 11) % 32;
                exp = (ra == 0) ? 16'h0000 : 16'(ra * 3);
                checks++;
                if (b.rdata[j*16 +: 16] !== exp) begin
                    failures++;
                    $display("FAIL sweep_read port=%0d addr=%0d got=%h expected %h",
                             j, ra, b.rdata[j*16 +: 16], exp);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (b.busy_vec !== 32'h0) begin
            failures++;
            $display("FAIL sweep_busy_vec got=%h expected 00000000", b.busy_vec);
        end
    endtask

    // ---------------- sequencing and report ----------------
    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        model_reset();
        b.we = 1'b0; b.waddr = '0; b.wdata = '0; b.raddr = '0;
        b.resv_en = 1'b0; b.resv_addr = '0;
        drive_idle(3, 4);
        test_reset();
        test_zero_reg();
        test_conflict();
        test_scoreboard();
        test_bypass();
        test_random();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
